serial_chunk_adder: RTL and testbench

- Multi-cycle, parametrised add/subtract unit; the next generation of the lab's single-cycle 8-bit ripple adder.
- Each cycle it processes one CHUNK-bit slice of WIDTH-bit operands, LSB slice first, and carries between slices through a register.
- Offers carry-in/borrow-in, a subtract mode, carry-out and signed overflow, with a start/ready/done handshake.
- Sits beside the datapath wherever a wide add is needed and the cost of one cycle per slice is acceptable.

---
 rtl/serial_adder_pkg.sv | 25 ++
 rtl/chunk_adder.sv | 29 ++
 rtl/serial_chunk_adder.sv | 163 ++++++++++++++++
 tb/tb_serial_chunk_adder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the serial chunk adder:
//   state_t    - FSM state encoding (S_IDLE, S_RUN, S_DONE), 2 bits
//   nchunk_of  - number of slice cycles for a given WIDTH/CHUNK
//   idx_width  - width of the chunk index counter, clog2(NCHUNK) but never 0
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int nchunk_of(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A single-slice configuration still needs a 1-bit index register.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// -----------------------------------------------------------------------------
// chunk_adder
// Combinational CHUNK-bit adder slice: {cout, s} = a + b + cin.
// Ports:
//   a, b   in  CHUNK  slice operands
//   cin    in  1      carry into bit 0
//   s      out CHUNK  slice sum
//   cout   out 1      carry out of bit CHUNK-1
//   c_msb  out 1      carry into bit CHUNK-1 (for signed overflow)
// -----------------------------------------------------------------------------
module chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  always_comb begin
    {cout, s} = a + b + cin;
    // Sum bit = a ^ b ^ carry_in at that position, so the carry into the
    // MSB falls out without a second adder. Also holds for CHUNK=1 (= cin).
    c_msb = s[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];
  end

endmodule

// File: rtl/serial_chunk_adder.sv
// -----------------------------------------------------------------------------
// serial_chunk_adder
// Multi-cycle add/subtract unit. Processes one CHUNK-bit slice per clock,
// LSB slice first, carrying between slices through a register.
//   sub=0: S = A + B + C0        sub=1: S = A - B - C0 (= A + ~B + ~C0)
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous, active-high reset
//   start  in   request, honoured only while ready=1
//   A, B   in   WIDTH operands, sampled on the accepting edge
//   C0     in   carry-in (add) / borrow-in (sub)
//   sub    in   subtract mode
//   ready  out  high in IDLE
//   done   out  one-cycle pulse while the new result is valid
//   S      out  WIDTH result, held until the next operation completes
//   Cout   out  carry-out (add) / not-borrow (sub)
//   V      out  two's-complement overflow of the WIDTH-bit result
// -----------------------------------------------------------------------------
module serial_chunk_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C0,
  input  logic             sub,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V
);

  localparam int NCHUNK = nchunk_of(WIDTH, CHUNK);
  localparam int IDXW   = idx_width(NCHUNK);
  localparam logic [IDXW-1:0]  LAST_IDX   = IDXW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({CHUNK{1'b1}});

  state_t state, state_nxt;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] res_nxt;
  logic             carry;
  logic [IDXW-1:0]  idx;
  logic             last_slice;

  logic [31:0]      base;
  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic [CHUNK-1:0] sum_sl;
  logic             c_out;
  logic             c_msb;

  // ---------------------------------------------------------------------------
  // Slice selection and merge
  // ---------------------------------------------------------------------------
  always_comb begin
    base       = 32'(idx) * 32'(CHUNK);
    a_sl       = CHUNK'(op_a >> base);
    b_sl       = CHUNK'(op_b >> base);
    last_slice = (idx == LAST_IDX);
    // Shadow with slice idx replaced by this cycle's sum.
    res_nxt    = (shadow & ~(SLICE_MASK << base)) | (WIDTH'(sum_sl) << base);
  end

  chunk_adder #(
    .CHUNK(CHUNK)
  ) u_chunk_adder (
    .a    (a_sl),
    .b    (b_sl),
    .cin  (carry),
    .s    (sum_sl),
    .cout (c_out),
    .c_msb(c_msb)
  );

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (last_slice) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      op_a   <= '0;
      op_b   <= '0;
      shadow <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      S      <= '0;
      Cout   <= 1'b0;
      V      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            // Subtraction is folded into the operands: A + ~B + ~C0.
            op_a   <= A;
            op_b   <= sub ? ~B : B;
            carry  <= sub ? ~C0 : C0;
            shadow <= '0;
            idx    <= '0;
          end
        end
        S_RUN: begin
          shadow <= res_nxt;
          carry  <= c_out;
          idx    <= idx + IDXW'(1);
          // S only changes here, so partial sums never reach the output.
          if (last_slice) begin
            S    <= res_nxt;
            Cout <= c_out;
            V    <= c_msb ^ c_out;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_chunk_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_chunk_adder
// Directed and randomised checks of serial_chunk_adder in four
// configurations: 32/8, 8/8, 12/4 and 16/1 (WIDTH/CHUNK).
// -----------------------------------------------------------------------------
module tb_serial_chunk_adder;

  logic        clk;
  logic        reset;
  logic [3:0]  start_v;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        c0_in;
  logic        sub_in;

  logic [3:0]  rdy;
  logic [3:0]  dn;
  logic [3:0]  co;
  logic [3:0]  ov;
  logic [31:0] s0;
  logic [7:0]  s1;
  logic [11:0] s2;
  logic [15:0] s3;

  int          sel;
  logic [31:0] sel_s;

  int n_cmp;
  int n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_chunk_adder #(.WIDTH(32), .CHUNK(8)) u0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .A(a_in), .B(b_in),
    .C0(c0_in), .sub(sub_in), .ready(rdy[0]), .done(dn[0]), .S(s0),
    .Cout(co[0]), .V(ov[0]));

  serial_chunk_adder #(.WIDTH(8), .CHUNK(8)) u1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .A(a_in[7:0]), .B(b_in[7:0]),
    .C0(c0_in), .sub(sub_in), .ready(rdy[1]), .done(dn[1]), .S(s1),
    .Cout(co[1]), .V(ov[1]));

  serial_chunk_adder #(.WIDTH(12), .CHUNK(4)) u2 (
    .clk(clk), .reset(reset), .start(start_v[2]), .A(a_in[11:0]), .B(b_in[11:0]),
    .C0(c0_in), .sub(sub_in), .ready(rdy[2]), .done(dn[2]), .S(s2),
    .Cout(co[2]), .V(ov[2]));

  serial_chunk_adder #(.WIDTH(16), .CHUNK(1)) u3 (
    .clk(clk), .reset(reset), .start(start_v[3]), .A(a_in[15:0]), .B(b_in[15:0]),
    .C0(c0_in), .sub(sub_in), .ready(rdy[3]), .done(dn[3]), .S(s3),
    .Cout(co[3]), .V(ov[3]));

  always_comb begin
    sel_s = '0;
    case (sel)
      0: sel_s = s0;
      1: sel_s = {24'b0, s1};
      2: sel_s = {20'b0, s2};
      3: sel_s = {16'b0, s3};
      default: sel_s = '0;
    endcase
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int width_of(input int k);
    case (k)
      0: return 32;
      1: return 8;
      2: return 12;
      default: return 16;
    endcase
  endfunction

  function automatic int nchunk_of_inst(input int k);
    case (k)
      0: return 4;
      1: return 1;
      2: return 3;
      default: return 16;
    endcase
  endfunction

  // Reference: (WIDTH+1)-bit add of A and (sub ? ~B : B) with (sub ? ~C0 : C0).
  // Returns {V, Cout, S}.
  function automatic logic [33:0] model(input int w, input logic [31:0] a,
                                        input logic [31:0] b, input logic c0,
                                        input logic sb);
    logic [31:0] mask, am, bm, s;
    logic [32:0] ext, ci;
    logic        cout, v;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    am   = a & mask;
    bm   = (sb ? ~b : b) & mask;
    ci   = {32'b0, (sb ? ~c0 : c0)};
    ext  = {1'b0, am} + {1'b0, bm} + ci;
    s    = ext[31:0] & mask;
    cout = ext[w];
    v    = (am[w-1] == bm[w-1]) && (s[w-1] != am[w-1]);
    return {v, cout, s};
  endfunction

  // One complete operation on instance k. Inputs are scrambled right after
  // the accepting edge to show they are not resampled.
  task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b,
                        input logic c0, input logic sb, input logic [31:0] es,
                        input logic ec, input logic ev, input string tag);
    int          n, cyc;
    logic [31:0] prev;
    n      = nchunk_of_inst(k);
    sel    = k;
    a_in   = a;
    b_in   = b;
    c0_in  = c0;
    sub_in = sb;
    start_v[k] = 1'b1;
    tick();
    start_v[k] = 1'b0;
    a_in   = ~a;
    b_in   = a ^ b ^ 32'h5A5A_A5A5;
    c0_in  = ~c0;
    sub_in = ~sb;
    prev   = sel_s;
    cyc    = 0;
    while (!dn[k] && cyc < n + 4) begin
      chk({tag, " ready_low"}, {32'b0, rdy[k]}, 33'd0);
      chk({tag, " s_held"}, {1'b0, sel_s}, {1'b0, prev});
      tick();
      cyc++;
    end
    chk({tag, " done_seen"}, {32'b0, dn[k]}, 33'd1);
    chk({tag, " latency"}, 33'(cyc), 33'(n));
    chk({tag, " S"}, {1'b0, sel_s}, {1'b0, es});
    chk({tag, " Cout"}, {32'b0, co[k]}, {32'b0, ec});
    chk({tag, " V"}, {32'b0, ov[k]}, {32'b0, ev});
    tick();
    chk({tag, " done_pulse"}, {32'b0, dn[k]}, 33'd0);
    chk({tag, " ready_back"}, {32'b0, rdy[k]}, 33'd1);
    chk({tag, " S_hold"}, {1'b0, sel_s}, {1'b0, es});
  endtask

  initial begin
    int          ndone;
    logic [31:0] ra, rb;
    logic        rc, rs;
    logic [33:0] m;

    n_cmp   = 0;
    n_err   = 0;
    sel     = 0;
    start_v = '0;
    a_in    = '0;
    b_in    = '0;
    c0_in   = 1'b0;
    sub_in  = 1'b0;
    reset   = 1'b1;
    tick();
    tick();
    reset   = 1'b0;

    chk("rst ready", {32'b0, rdy[0]}, 33'd1);
    chk("rst done", {32'b0, dn[0]}, 33'd0);
    chk("rst S", {1'b0, s0}, 33'd0);
    chk("rst Cout", {32'b0, co[0]}, 33'd0);
    chk("rst V", {32'b0, ov[0]}, 33'd0);
    chk("rst ready all", {29'b0, rdy}, 33'hF);

    run_op(0, 32'h0000_00FF, 32'h1, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, "add_ff_1");
    run_op(0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "add_wrap");
    run_op(0, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "add_ovf");
    run_op(0, 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub_5_7");
    run_op(0, 32'd7, 32'd5, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0, "sub_7_5_b");
    run_op(0, 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, "sub_ovf");
    run_op(0, 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 32'h2222_2222, 1'b0, 1'b0, "add_cin");

    // start during RUN is ignored: one done, first result kept
    sel    = 0;
    a_in   = 32'h10;
    b_in   = 32'h20;
    c0_in  = 1'b0;
    sub_in = 1'b0;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    a_in = 32'h1000;
    b_in = 32'h1;
    tick();
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (dn[0]) begin
        ndone++;
        chk("ignore S at done", {1'b0, s0}, 33'h30);
      end
      tick();
    end
    chk("ignore done count", 33'(ndone), 33'd1);
    chk("ignore S after", {1'b0, s0}, 33'h30);
    chk("ignore ready", {32'b0, rdy[0]}, 33'd1);

    // reset at E2 aborts the operation
    a_in   = 32'h1234_5678;
    b_in   = 32'h1;
    c0_in  = 1'b0;
    sub_in = 1'b0;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort ready", {32'b0, rdy[0]}, 33'd1);
    chk("abort S", {1'b0, s0}, 33'd0);
    chk("abort done", {32'b0, dn[0]}, 33'd0);
    chk("abort Cout", {32'b0, co[0]}, 33'd0);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (dn[0]) ndone++;
      tick();
    end
    chk("abort no done", 33'(ndone), 33'd0);
    run_op(0, 32'd3, 32'd4, 1'b1, 1'b0, 32'd8, 1'b0, 1'b0, "after_abort");

    // directed corner cases on the narrow configurations
    run_op(1, 32'h7F, 32'h01, 1'b0, 1'b0, 32'h80, 1'b0, 1'b1, "w8_ovf");
    run_op(2, 32'hFFF, 32'h001, 1'b0, 1'b0, 32'h000, 1'b1, 1'b0, "w12_wrap");
    run_op(3, 32'h0000, 32'h0001, 1'b0, 1'b1, 32'hFFFF, 1'b0, 1'b0, "w16_sub");

    // random sweep against the reference model
    for (int k = 1; k < 4; k++) begin
      for (int i = 0; i < 1000; i++) begin
        ra = $urandom;
        rb = $urandom;
        rc = 1'($urandom_range(0, 1));
        rs = 1'($urandom_range(0, 1));
        m  = model(width_of(k), ra, rb, rc, rs);
        run_op(k, ra, rb, rc, rs, m[31:0], m[32], m[33], $sformatf("rnd_w%0d_%0d", width_of(k), i));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
